// File: rtl/rv32i_wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32i_wb_pkg : shared types and constants for the RV32I write-back   |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package rv32i_wb_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      WB_SEL_ALU = 3'd0,
      WB_SEL_MEM = 3'd1,
      WB_SEL_PC4 = 3'd2,
      WB_SEL_CSR = 3'd3,
      WB_SEL_IMM = 3'd4
   } wb_sel_e;

   typedef enum logic [1:0] {
      WB_IDLE     = 2'd0,
      WB_WAIT_MEM = 2'd1,
      WB_DRAIN    = 2'd2
   } wb_state_e;

   localparam logic [2:0] C_F3_LB  = 3'b000;
   localparam logic [2:0] C_F3_LH  = 3'b001;
   localparam logic [2:0] C_F3_LW  = 3'b010;
   localparam logic [2:0] C_F3_LBU = 3'b100;
   localparam logic [2:0] C_F3_LHU = 3'b101;

   // x0 is hard-wired to zero, so it never receives a write pulse.
   function automatic logic rf_write_en(input logic we, input logic [REG_ADDR_W-1:0] rd);
      return we & (rd != '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_wb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32i_wb_if : MEM-stage / register-file bus of the write-back stage  |
// | Optional i_csr_rdata under RV32I_WB_CSR_EN.  Revision : 1.0           |
// +----------------------------------------------------------------------+
interface rv32i_wb_if;
   import rv32i_wb_pkg::*;

   logic                  i_valid;
   logic                  o_ready;
   logic [2:0]            i_wb_sel;
   logic [REG_ADDR_W-1:0] i_rd;
   logic                  i_rd_we;
   logic [XLEN-1:0]       i_alu_result;
   logic [XLEN-1:0]       i_pc_plus4;
   logic [XLEN-1:0]       i_imm;
`ifdef RV32I_WB_CSR_EN
   logic [XLEN-1:0]       i_csr_rdata;
`endif
   logic [2:0]            i_funct3;
   logic [1:0]            i_byte_off;
   logic                  i_mem_rvalid;
   logic [XLEN-1:0]       i_mem_rdata;
   logic                  i_flush;
   logic                  o_rf_we;
   logic [REG_ADDR_W-1:0] o_rf_rd;
   logic [XLEN-1:0]       o_rf_wdata;

   modport slave (
`ifdef RV32I_WB_CSR_EN
      input  i_csr_rdata,
`endif
      input  i_valid, i_wb_sel, i_rd, i_rd_we, i_alu_result, i_pc_plus4, i_imm,
      input  i_funct3, i_byte_off, i_mem_rvalid, i_mem_rdata, i_flush,
      output o_ready, o_rf_we, o_rf_rd, o_rf_wdata
   );

   modport master (
`ifdef RV32I_WB_CSR_EN
      output i_csr_rdata,
`endif
      output i_valid, i_wb_sel, i_rd, i_rd_we, i_alu_result, i_pc_plus4, i_imm,
      output i_funct3, i_byte_off, i_mem_rvalid, i_mem_rdata, i_flush,
      input  o_ready, o_rf_we, o_rf_rd, o_rf_wdata
   );

endinterface
`default_nettype wire

// File: rtl/rv32i_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32i_load_align : shifts a loaded word and sign/zero-extends it      |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module rv32i_load_align
   import rv32i_wb_pkg::*;
(
   input  wire logic [XLEN-1:0] i_rdata,
   input  wire logic [1:0]      i_byte_off,
   input  wire logic [2:0]      i_funct3,
   output logic      [XLEN-1:0] o_data
);

   logic [XLEN-1:0] w_shifted;

   // A halfword at offset 3 runs off the word; the shift fills the upper byte with 0.
   assign w_shifted = i_rdata >> {i_byte_off, 3'b000};

   always_comb begin
      o_data = w_shifted;
      case (i_funct3)
         C_F3_LB:  o_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
         C_F3_LH:  o_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
         C_F3_LBU: o_data = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
         C_F3_LHU: o_data = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
         default:  o_data = w_shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/rv32i_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32i_wb_stage : registered write-back with load wait and flush drain |
// | CSR source enabled by RV32I_WB_CSR_EN.  Revision : 1.0                |
// +----------------------------------------------------------------------+
module rv32i_wb_stage
   import rv32i_wb_pkg::*;
(
   input  wire logic i_clk,
   input  wire logic i_rst_n,
   rv32i_wb_if.slave bus
);

   wb_state_e             state_q, state_d;
   logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
   logic                  ld_we_q, ld_we_d;
   logic [2:0]            ld_f3_q, ld_f3_d;
   logic [1:0]            ld_off_q, ld_off_d;
   logic                  rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

   logic [XLEN-1:0]       w_sel_data;
   logic                  w_sel_ok;
   logic [XLEN-1:0]       w_ld_data;
   logic                  w_accept;

   rv32i_load_align u_align (
      .i_rdata    (bus.i_mem_rdata),
      .i_byte_off (ld_off_q),
      .i_funct3   (ld_f3_q),
      .o_data     (w_ld_data)
   );

   // Unknown selects produce zero data and suppress the write.
   always_comb begin
      w_sel_data = '0;
      w_sel_ok   = 1'b0;
      case (bus.i_wb_sel)
         WB_SEL_ALU: begin w_sel_data = bus.i_alu_result; w_sel_ok = 1'b1; end
         WB_SEL_PC4: begin w_sel_data = bus.i_pc_plus4;   w_sel_ok = 1'b1; end
         WB_SEL_IMM: begin w_sel_data = bus.i_imm;        w_sel_ok = 1'b1; end
`ifdef RV32I_WB_CSR_EN
         WB_SEL_CSR: begin w_sel_data = bus.i_csr_rdata;  w_sel_ok = 1'b1; end
`endif
         default:    begin w_sel_data = '0;               w_sel_ok = 1'b0; end
      endcase
   end

   assign w_accept = bus.i_valid & (state_q == WB_IDLE) & ~bus.i_flush;

   always_comb begin
      state_d    = state_q;
      ld_rd_d    = ld_rd_q;
      ld_we_d    = ld_we_q;
      ld_f3_d    = ld_f3_q;
      ld_off_d   = ld_off_q;
      rf_we_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      case (state_q)
         WB_IDLE: begin
            if (w_accept) begin
               if (bus.i_wb_sel == WB_SEL_MEM) begin
                  ld_rd_d  = bus.i_rd;
                  ld_we_d  = bus.i_rd_we;
                  ld_f3_d  = bus.i_funct3;
                  ld_off_d = bus.i_byte_off;
                  state_d  = WB_WAIT_MEM;
               end else begin
                  rf_rd_d    = bus.i_rd;
                  rf_wdata_d = w_sel_data;
                  rf_we_d    = w_sel_ok & rf_write_en(bus.i_rd_we, bus.i_rd);
               end
            end
         end
         WB_WAIT_MEM: begin
            // A flush coinciding with the response simply drops the data.
            if (bus.i_mem_rvalid) begin
               if (!bus.i_flush) begin
                  rf_rd_d    = ld_rd_q;
                  rf_wdata_d = w_ld_data;
                  rf_we_d    = rf_write_en(ld_we_q, ld_rd_q);
               end
               state_d = WB_IDLE;
            end else if (bus.i_flush) begin
               state_d = WB_DRAIN;
            end
         end
         WB_DRAIN: begin
            if (bus.i_mem_rvalid) begin
               state_d = WB_IDLE;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= WB_IDLE;
         ld_rd_q    <= '0;
         ld_we_q    <= 1'b0;
         ld_f3_q    <= 3'b000;
         ld_off_q   <= 2'b00;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         ld_rd_q    <= ld_rd_d;
         ld_we_q    <= ld_we_d;
         ld_f3_q    <= ld_f3_d;
         ld_off_q   <= ld_off_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign bus.o_ready    = (state_q == WB_IDLE);
   assign bus.o_rf_we    = rf_we_q;
   assign bus.o_rf_rd    = rf_rd_q;
   assign bus.o_rf_wdata = rf_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv32i_wb_stage : scoreboard bench with a reference model           |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_rv32i_wb_stage;
   import rv32i_wb_pkg::*;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   exp_t   exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rv32i_wb_if bus();

   rv32i_wb_stage dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: load result from byte lanes with plain arithmetic.
   function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [1:0] off,
                                          input logic [2:0] f3);
      logic [31:0] s, b, h;
      s = rdata >> (8 * off);
      b = s % 256;
      h = s % 65536;
      case (f3)
         3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return s;
      endcase
   endfunction

   function automatic bit m_src(input logic [2:0] sel, input logic [31:0] alu, input logic [31:0] pc4,
                                input logic [31:0] imm, input logic [31:0] csr, output logic [31:0] d);
      d = 32'd0;
      case (sel)
         3'd0: begin d = alu; return 1'b1; end
         3'd2: begin d = pc4; return 1'b1; end
         3'd4: begin d = imm; return 1'b1; end
`ifdef RV32I_WB_CSR_EN
         3'd3: begin d = csr; return 1'b1; end
`endif
         default: return 1'b0;
      endcase
   endfunction

   // Monitor: every write pulse must match the oldest expected write, in the expected cycle.
   always @(negedge clk) begin
      if (bus.o_rf_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: rd=%0d data=0x%08h cyc=%0d, none expected",
                     bus.o_rf_rd, bus.o_rf_wdata, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.o_rf_rd !== e.rd || bus.o_rf_wdata !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL rf_write: got rd=%0d data=0x%08h cyc=%0d expected rd=%0d data=0x%08h cyc=%0d",
                        bus.o_rf_rd, bus.o_rf_wdata, cyc, e.rd, e.data, e.cyc);
            end
         end
      end
   end

   task automatic push(input logic [4:0] rd, input logic [31:0] data);
      exp_t e;
      e.rd = rd; e.data = data; e.cyc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic clear_inputs();
      bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_mem_rvalid = 1'b0;
   endtask

   task automatic idle_cycle();
      clear_inputs();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [2:0] sel, input logic [4:0] rd, input logic we,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                        input logic [31:0] csr, input bit flush, input bit spur);
      logic [31:0] d;
      bit ok;
      bus.i_valid = 1'b1; bus.i_wb_sel = sel; bus.i_rd = rd; bus.i_rd_we = we;
      bus.i_alu_result = alu; bus.i_pc_plus4 = pc4; bus.i_imm = imm;
`ifdef RV32I_WB_CSR_EN
      bus.i_csr_rdata = csr;
`endif
      bus.i_funct3 = 3'($urandom); bus.i_byte_off = 2'($urandom);
      bus.i_flush = flush; bus.i_mem_rvalid = spur; bus.i_mem_rdata = $urandom;
      chk("ready_idle", 32'(bus.o_ready), 32'd1);
      @(posedge clk); #1;
      ok = m_src(sel, alu, pc4, imm, csr, d);
      if (!flush) begin
         if (ok && we && rd != 5'd0) push(rd, d);
         chk("src_wdata", bus.o_rf_wdata, d);
         chk("src_rd", 32'(bus.o_rf_rd), 32'(rd));
      end
      clear_inputs();
   endtask

   task automatic load(input logic [4:0] rd, input logic we, input logic [2:0] f3, input logic [1:0] off,
                       input logic [31:0] rdata, input int waits, input int flush_at, input bit flush_rv);
      bit flushed = 1'b0;
      bus.i_valid = 1'b1; bus.i_wb_sel = 3'd1; bus.i_rd = rd; bus.i_rd_we = we;
      bus.i_funct3 = f3; bus.i_byte_off = off; bus.i_flush = 1'b0; bus.i_mem_rvalid = 1'b0;
      chk("ready_before_load", 32'(bus.o_ready), 32'd1);
      @(posedge clk); #1;
      // Scramble the MEM-side fields: the stage must use what it latched.
      bus.i_valid = 1'b0; bus.i_rd = 5'($urandom); bus.i_rd_we = 1'($urandom);
      bus.i_funct3 = 3'($urandom); bus.i_byte_off = 2'($urandom);
      chk("ready_wait", 32'(bus.o_ready), 32'd0);
      for (int i = 0; i < waits; i++) begin
         bus.i_flush = (i == flush_at) || (flushed && ($urandom_range(0, 1) == 1));
         bus.i_valid = 1'($urandom);
         bus.i_mem_rdata = $urandom;
         @(posedge clk); #1;
         if (bus.i_flush) flushed = 1'b1;
         bus.i_flush = 1'b0;
         chk("ready_waiting", 32'(bus.o_ready), 32'd0);
      end
      bus.i_valid = 1'b0;
      bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = rdata; bus.i_flush = flush_rv;
      @(posedge clk); #1;
      if (!flushed && !flush_rv && we && rd != 5'd0) push(rd, m_load(rdata, off, f3));
      clear_inputs();
      chk("ready_after_resp", 32'(bus.o_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      bus.i_wb_sel = 3'd0; bus.i_rd = 5'd0; bus.i_rd_we = 1'b0;
      bus.i_alu_result = '0; bus.i_pc_plus4 = '0; bus.i_imm = '0;
`ifdef RV32I_WB_CSR_EN
      bus.i_csr_rdata = '0;
`endif
      bus.i_funct3 = 3'd0; bus.i_byte_off = 2'd0; bus.i_mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_ready", 32'(bus.o_ready), 32'd1);
      chk("reset_we", 32'(bus.o_rf_we), 32'd0);
      chk("reset_rd", 32'(bus.o_rf_rd), 32'd0);
      chk("reset_wdata", bus.o_rf_wdata, 32'd0);

      issue(3'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      issue(3'd4, 5'd6, 1'b1, 32'h0, 32'h0, 32'hFFFF_0000, 32'h0, 1'b0, 1'b0);
      idle_cycle();

      load(5'd7, 1'b1, 3'b000, 2'd2, 32'h0080_0000, 0, -1, 1'b0);
      chk("lb_data", bus.o_rf_wdata, 32'hFFFF_FF80);
      load(5'd8, 1'b1, 3'b101, 2'd2, 32'hBEEF_0000, 3, -1, 1'b0);
      chk("lhu_data", bus.o_rf_wdata, 32'h0000_BEEF);
      load(5'd9, 1'b1, 3'b001, 2'd3, 32'h80AB_CDEF, 1, -1, 1'b0);
      chk("lh_off3_data", bus.o_rf_wdata, 32'h0000_0080);
      load(5'd10, 1'b1, 3'b010, 2'd0, 32'h1234_5678, 2, 0, 1'b0);
      load(5'd11, 1'b1, 3'b010, 2'd0, 32'h1234_5678, 1, -1, 1'b1);

      issue(3'd0, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      issue(3'd2, 5'd12, 1'b0, 32'h0, 32'h0000_0104, 32'h0, 32'h0, 1'b0, 1'b0);
      issue(3'd0, 5'd13, 1'b1, 32'hCAFE_0001, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      issue(3'd6, 5'd14, 1'b1, 32'h1111_1111, 32'h2, 32'h3, 32'h4, 1'b0, 1'b0);
      idle_cycle();

      // Reset while a load is outstanding; the late response must be ignored.
      bus.i_valid = 1'b1; bus.i_wb_sel = 3'd1; bus.i_rd = 5'd15; bus.i_rd_we = 1'b1;
      bus.i_funct3 = 3'b010; bus.i_byte_off = 2'd0;
      @(posedge clk); #1;
      clear_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      clear_inputs();
      chk("rst_load_we", 32'(bus.o_rf_we), 32'd0);
      chk("rst_load_rd", 32'(bus.o_rf_rd), 32'd0);
      chk("rst_load_wdata", bus.o_rf_wdata, 32'd0);
      chk("rst_load_ready", 32'(bus.o_ready), 32'd1);

      for (int n = 0; n < 300; n++) begin
         int k;
         k = $urandom_range(0, 9);
         if (k < 6) begin
            logic [2:0] sel;
            do sel = 3'($urandom); while (sel == 3'd1);
            issue(sel, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
         end else if (k < 9) begin
            int w, fa;
            w  = $urandom_range(0, 3);
            fa = ($urandom_range(0, 2) == 0 && w > 0) ? $urandom_range(0, w - 1) : -1;
            load(5'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom, w, fa,
                 ($urandom_range(0, 5) == 0));
         end else begin
            idle_cycle();
         end
      end

      repeat (3) idle_cycle();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
